adder_result_checker: RTL and testbench

- Self-checking monitor that sits directly downstream of the combinational adder stage (o = a + b).
- Samples operand/result triples, recomputes the expected sum at full width, and reports each pass or fail.
- Keeps saturating pass and fail counters, a sticky error flag, and a capture of the first failing triple.
- The pyvpi test harness reads these outputs at end of run, replacing ad-hoc $display checking.

---
 rtl/adder_result_checker.sv | 112 +++++++++++
 tb/tb_adder_result_checker.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_checker.sv
// Monitor for the a+b adder stage: recomputes the full-width sum for each sampled triple,
// reports per-sample pass/fail, and keeps saturating counters, a sticky error and the first failure.
module adder_result_checker #(
  parameter int WIDTH       = 8,
  parameter int CNT_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   o,
  output logic             cmp_valid,
  output logic             cmp_pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
  output logic [WIDTH-1:0] first_a,
  output logic [WIDTH-1:0] first_b,
  output logic [WIDTH:0]   first_o,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_e;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   o;
  } sample_t;

  localparam int STAGES = 2;

  state_e          st;
  logic [STAGES:0] vld_pipe;  // [0] capture, [1] compare, [2] reported
  sample_t         s1, s2;
  logic            s2_pass;
  logic [WIDTH:0]  s1_exp;
  logic            s1_pass;
  logic            halt_now;
  logic            take;

  assign s1_exp  = {1'b0, s1.a} + {1'b0, s1.b};
  assign s1_pass = (s1.o == s1_exp);

  // Halting is decided from the stage-1 compare so the very next sample is already refused.
  assign halt_now = STOP_ON_ERR && vld_pipe[0] && !s1_pass && (st == RUN);
  assign take     = in_valid && (st == RUN) && !halt_now;

  assign state     = st;
  assign cmp_valid = vld_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st       <= IDLE;
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
      s2_pass  <= 1'b0;
      cmp_pass <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      err      <= 1'b0;
      first_a  <= '0;
      first_b  <= '0;
      first_o  <= '0;
    end else if (clr) begin
      st       <= IDLE;
      vld_pipe <= '0;
      cmp_pass <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      err      <= 1'b0;
      first_a  <= '0;
      first_b  <= '0;
      first_o  <= '0;
    end else begin
      case (st)
        IDLE:    if (start && !stop) st <= RUN;
        RUN:     if (stop) st <= IDLE;
                 else if (halt_now) st <= HALT;
        HALT:    st <= HALT;
        default: st <= IDLE;
      endcase

      vld_pipe <= {vld_pipe[STAGES-1:0], take};
      if (take) s1 <= {a, b, o};
      s2       <= s1;
      s2_pass  <= s1_pass;
      cmp_pass <= vld_pipe[1] & s2_pass;

      if (vld_pipe[1]) begin
        if (s2_pass) begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
        end else begin
          if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
          err <= 1'b1;
          if (!err) begin
            first_a <= s2.a;
            first_b <= s2.b;
            first_o <= s2.o;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_result_checker.sv
// Bench for adder_result_checker: three instances (default, halt-on-error, 2-bit counters)
// share one stimulus stream; expectations come from plain sum arithmetic and a timed queue.
module tb_adder_result_checker;

  logic clk, rst_n, start, stop, clr, in_valid;
  logic [7:0] a, b;
  logic [8:0] o;

  logic        m_cv, m_cp, m_err;
  logic [15:0] m_pc, m_fc;
  logic [7:0]  m_fa, m_fb;
  logic [8:0]  m_fo;
  logic [1:0]  m_st;

  logic        h_cv, h_cp, h_err;
  logic [15:0] h_pc, h_fc;
  logic [7:0]  h_fa, h_fb;
  logic [8:0]  h_fo;
  logic [1:0]  h_st;

  logic        s_cv, s_cp, s_err;
  logic [1:0]  s_pc, s_fc;
  logic [7:0]  s_fa, s_fb;
  logic [8:0]  s_fo;
  logic [1:0]  s_st;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  adder_result_checker #(.WIDTH(8), .CNT_W(16), .STOP_ON_ERR(1'b0)) u_m (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clr(clr), .in_valid(in_valid),
    .a(a), .b(b), .o(o), .cmp_valid(m_cv), .cmp_pass(m_cp), .pass_cnt(m_pc), .fail_cnt(m_fc),
    .err(m_err), .first_a(m_fa), .first_b(m_fb), .first_o(m_fo), .state(m_st));

  adder_result_checker #(.WIDTH(8), .CNT_W(16), .STOP_ON_ERR(1'b1)) u_h (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clr(clr), .in_valid(in_valid),
    .a(a), .b(b), .o(o), .cmp_valid(h_cv), .cmp_pass(h_cp), .pass_cnt(h_pc), .fail_cnt(h_fc),
    .err(h_err), .first_a(h_fa), .first_b(h_fb), .first_o(h_fo), .state(h_st));

  adder_result_checker #(.WIDTH(8), .CNT_W(2), .STOP_ON_ERR(1'b0)) u_s (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clr(clr), .in_valid(in_valid),
    .a(a), .b(b), .o(o), .cmp_valid(s_cv), .cmp_pass(s_cp), .pass_cnt(s_pc), .fail_cnt(s_fc),
    .err(s_err), .first_a(s_fa), .first_b(s_fb), .first_o(s_fo), .state(s_st));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [8:0] to);
    in_valid = 1'b1; a = ta; b = tb; o = to;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drain(3);
    checks++;
    if (m_st !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", m_st); end
    checks++;
    if ({m_cv, m_cp, m_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b exp 000", {m_cv, m_cp, m_err});
    end
    checks++;
    if ({m_pc, m_fc} !== 32'd0) begin
      errors++; $display("FAIL reset_cnt: got %0h/%0h exp 0/0", m_pc, m_fc);
    end
    checks++;
    if ({m_fa, m_fb, m_fo} !== 25'd0) begin
      errors++; $display("FAIL reset_first: got %0h %0h %0h exp 0 0 0", m_fa, m_fb, m_fo);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    do_clr();
    do_start();
    checks++;
    if (m_st !== 2'd1) begin errors++; $display("FAIL start_run: got %0d exp 1", m_st); end
    send(8'd3, 8'd4, 9'd7);
    tick();
    checks++;
    if (m_cv !== 1'b0) begin errors++; $display("FAIL basic_early: cmp_valid got %b exp 0", m_cv); end
    tick();
    checks++;
    if ({m_cv, m_cp} !== 2'b11) begin
      errors++; $display("FAIL basic_cmp: valid/pass got %b exp 11", {m_cv, m_cp});
    end
    checks++;
    if (m_pc !== 16'd1 || m_fc !== 16'd0 || m_err !== 1'b0) begin
      errors++; $display("FAIL basic_cnt: got p=%0d f=%0d e=%b exp 1 0 0", m_pc, m_fc, m_err);
    end
    tick();
    checks++;
    if (m_cv !== 1'b0) begin errors++; $display("FAIL basic_strobe: cmp_valid got %b exp 0", m_cv); end
  endtask

  task automatic test_overflow();
    do_clr();
    do_start();
    send(8'hFF, 8'h01, 9'h100);
    send(8'hFF, 8'h01, 9'h000);
    tick();
    checks++;
    if ({m_cv, m_cp} !== 2'b11) begin
      errors++; $display("FAIL ovf_pass: valid/pass got %b exp 11", {m_cv, m_cp});
    end
    tick();
    checks++;
    if ({m_cv, m_cp} !== 2'b10) begin
      errors++; $display("FAIL ovf_fail: valid/pass got %b exp 10", {m_cv, m_cp});
    end
    checks++;
    if (m_pc !== 16'd1 || m_fc !== 16'd1 || m_err !== 1'b1) begin
      errors++; $display("FAIL ovf_cnt: got p=%0d f=%0d e=%b exp 1 1 1", m_pc, m_fc, m_err);
    end
    checks++;
    if (m_fa !== 8'hFF || m_fb !== 8'h01 || m_fo !== 9'h000) begin
      errors++; $display("FAIL ovf_first: got %0h %0h %0h exp ff 1 0", m_fa, m_fb, m_fo);
    end
  endtask

  task automatic test_two_fails();
    do_clr();
    do_start();
    send(8'd1, 8'd1, 9'd3);
    send(8'd2, 8'd2, 9'd5);
    drain(3);
    checks++;
    if (m_fc !== 16'd2 || m_pc !== 16'd0 || m_err !== 1'b1) begin
      errors++; $display("FAIL two_fails_cnt: got p=%0d f=%0d e=%b exp 0 2 1", m_pc, m_fc, m_err);
    end
    checks++;
    if (m_fa !== 8'd1 || m_fb !== 8'd1 || m_fo !== 9'd3) begin
      errors++; $display("FAIL two_fails_first: got %0d %0d %0d exp 1 1 3", m_fa, m_fb, m_fo);
    end
  endtask

  task automatic test_halt();
    do_clr();
    do_start();
    send(8'd10, 8'd20, 9'd30);
    send(8'd5, 8'd6, 9'd12);
    send(8'd7, 8'd8, 9'd15);
    send(8'd9, 8'd9, 9'd18);
    send(8'd100, 8'd200, 9'd300);
    drain(4);
    checks++;
    if (h_st !== 2'd2) begin errors++; $display("FAIL halt_state: got %0d exp 2", h_st); end
    checks++;
    if (h_pc !== 16'd1 || h_fc !== 16'd1 || h_err !== 1'b1) begin
      errors++; $display("FAIL halt_cnt: got p=%0d f=%0d e=%b exp 1 1 1", h_pc, h_fc, h_err);
    end
    checks++;
    if (m_pc !== 16'd4 || m_fc !== 16'd1 || m_st !== 2'd1) begin
      errors++; $display("FAIL nohalt_cnt: got p=%0d f=%0d st=%0d exp 4 1 1", m_pc, m_fc, m_st);
    end
    do_start();
    checks++;
    if (h_st !== 2'd2) begin errors++; $display("FAIL halt_start: got %0d exp 2", h_st); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (h_st !== 2'd2) begin errors++; $display("FAIL halt_stop: got %0d exp 2", h_st); end
    do_clr();
    checks++;
    if (h_st !== 2'd0 || h_pc !== 16'd0 || h_fc !== 16'd0 || h_err !== 1'b0 || h_fo !== 9'd0) begin
      errors++;
      $display("FAIL halt_clr: got st=%0d p=%0d f=%0d e=%b fo=%0h exp 0 0 0 0 0", h_st, h_pc, h_fc, h_err, h_fo);
    end
  endtask

  task automatic test_saturate();
    do_clr();
    do_start();
    for (int i = 0; i < 5; i++) send(8'(i), 8'(i * 3), 9'(i * 4));
    drain(3);
    checks++;
    if (s_pc !== 2'd3 || s_fc !== 2'd0) begin
      errors++; $display("FAIL sat_cnt: got p=%0d f=%0d exp 3 0", s_pc, s_fc);
    end
    checks++;
    if (m_pc !== 16'd5) begin errors++; $display("FAIL sat_wide: got %0d exp 5", m_pc); end
  endtask

  task automatic test_start_stop();
    int seen;
    do_clr();
    start = 1'b1; stop = 1'b1;
    send(8'd1, 8'd2, 9'd3);
    start = 1'b0; stop = 1'b0;
    checks++;
    if (m_st !== 2'd0) begin errors++; $display("FAIL startstop_state: got %0d exp 0", m_st); end
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (m_cv === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || m_pc !== 16'd0 || m_fc !== 16'd0) begin
      errors++; $display("FAIL startstop_sample: got strobes=%0d p=%0d f=%0d exp 0 0 0", seen, m_pc, m_fc);
    end
    do_start();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (m_st !== 2'd0) begin errors++; $display("FAIL run_stop: got %0d exp 0", m_st); end
  endtask

  task automatic test_reset_midflight();
    int seen;
    do_clr();
    do_start();
    send(8'd5, 8'd5, 9'd10);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (m_cv === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || m_pc !== 16'd0 || m_fc !== 16'd0 || m_st !== 2'd0) begin
      errors++; $display("FAIL rst_flight: got strobes=%0d p=%0d f=%0d st=%0d exp 0 0 0 0", seen, m_pc, m_fc, m_st);
    end
  endtask

  typedef struct {
    int due;
    bit pass;
  } exp_t;

  task automatic test_random();
    exp_t q[$];
    int npass, nfail;
    bit got_first;
    logic [7:0] fa, fb;
    logic [8:0] fo;
    bit issued, ok;
    npass = 0; nfail = 0; got_first = 0;
    fa = '0; fb = '0; fo = '0;
    do_clr();
    do_start();
    for (int i = 0; i < 300; i++) begin
      issued = (i < 250) && ($urandom_range(3, 0) != 0);
      in_valid = issued;
      a = 8'($urandom);
      b = 8'($urandom);
      o = ($urandom_range(1, 0) == 1) ? 9'(int'(a) + int'(b)) : 9'($urandom);
      tick();
      if (q.size() > 0 && q[0].due == cyc) begin
        checks++;
        if (m_cv !== 1'b1 || m_cp !== q[0].pass) begin
          errors++; $display("FAIL rand_cmp: cyc %0d got v=%b p=%b exp 1 %b", cyc, m_cv, m_cp, q[0].pass);
        end
        void'(q.pop_front());
      end else begin
        checks++;
        if (m_cv !== 1'b0) begin errors++; $display("FAIL rand_idle: cyc %0d cmp_valid got %b exp 0", cyc, m_cv); end
      end
      if (issued) begin
        ok = (int'(o) == int'(a) + int'(b));
        q.push_back('{due: cyc + 2, pass: ok});
        if (ok) npass++;
        else begin
          nfail++;
          if (!got_first) begin got_first = 1; fa = a; fb = b; fo = o; end
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL rand_drain: pending %0d exp 0", q.size()); end
    checks++;
    if (int'(m_pc) != npass || int'(m_fc) != nfail || m_err !== (nfail > 0)) begin
      errors++; $display("FAIL rand_cnt: got p=%0d f=%0d e=%b exp %0d %0d", m_pc, m_fc, m_err, npass, nfail);
    end
    checks++;
    if (m_fa !== fa || m_fb !== fb || m_fo !== fo) begin
      errors++; $display("FAIL rand_first: got %0h %0h %0h exp %0h %0h %0h", m_fa, m_fb, m_fo, fa, fb, fo);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; clr = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; o = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_two_fails();
    test_halt();
    test_saturate();
    test_start_stop();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
